mul_issue_control: RTL and testbench
====================================

Name: mul_issue_control

Overview:
Sequencing controller for the iterative multiplier behind the EX-stage ALU. It detects a valid MUL (ALU control code 3'b011) in EX and issues a one-cycle start to the multiplier. It freezes the pipeline (PC, IF/ID, ID/EX, EX hold) for the multiply duration. It then selects the multiplier result into EX/MEM for exactly one cycle. Non-MUL operations pass through with no stall.

Parameters:
MUL_CYCLES, 4, cycles from mul_start_o to multiplier result valid; legal range 1..2**CNT_W
CNT_W, 3, width of internal down-counter and mul_count_o

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
ex_valid_i  input  1  EX stage holds a valid instruction
ALUCtrl_i  input  3  ALU control code of EX instruction; 3'b011 = MUL
flush_i  input  1  kill EX instruction (branch/exception)
mul_start_o  output  1  one-cycle start pulse to multiplier
mul_busy_o  output  1  multiplier operation in progress (RUN state)
stall_o  output  1  freeze PC, IF/ID, ID/EX; hold EX
result_sel_o  output  1  1 = EX/MEM captures multiplier result instead of ALU result
mul_count_o  output  CNT_W  remaining RUN cycles (debug/visibility)

Behaviour:
- Request: mul_req = ex_valid_i & (ALUCtrl_i == 3'b011) & ~flush_i. ALUCtrl_i is ignored when ex_valid_i = 0.
- States: IDLE, RUN, DONE. Reset state is IDLE. Counter resets to 0.
- While rst_i = 1, all outputs are 0, including the combinational ones. The first active cycle after reset is IDLE.
- IDLE:
  - mul_start_o = stall_o = mul_req (combinational).
  - On mul_req: load counter with MUL_CYCLES-1 and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - stall_o = 1, mul_busy_o = 1.
  - If flush_i: go to IDLE (abort), stall_o drops the next cycle, result_sel_o is never asserted.
  - Else if counter == 0: go to DONE.
  - Else decrement the counter.
- DONE:
  - stall_o = 0, result_sel_o = ~flush_i.
  - Always go to IDLE next cycle, unconditionally.
  - The MUL is still visible on ALUCtrl_i in this cycle and must NOT retrigger.
- Timing, with start at cycle T:
  - RUN occupies T+1 .. T+MUL_CYCLES; DONE is at T+MUL_CYCLES+1.
  - stall_o is high for MUL_CYCLES+1 cycles (T .. T+MUL_CYCLES).
  - result_sel_o is high only at T+MUL_CYCLES+1.
- mul_count_o: the counter value in RUN, 0 in IDLE and DONE.
- MUL_CYCLES = 1: counter loads 0, one RUN cycle, then DONE.
- Back-to-back MULs: the second is detected in the IDLE cycle after DONE, so there is no overlap and each MUL gets its own start pulse.
- Non-MUL codes (010, 110, 000, 001) never assert any output.
- Reset mid-RUN or mid-DONE: IDLE on the next edge; no start or select pulse is emitted.
- Counter must not underflow or wrap; it is only decremented while nonzero in RUN.

Test Plan:
(MUL_CYCLES=4 unless noted)
- Reset: hold rst_i 2 cycles with ex_valid_i=1 and ALUCtrl_i=011 -> all outputs 0 during reset; first post-reset cycle has mul_start_o=1 and stall_o=1.
- Single MUL: ex_valid_i=1, ALUCtrl_i=011 at T -> mul_start_o only at T; stall_o at T..T+4; mul_busy_o at T+1..T+4; mul_count_o 3,2,1,0; result_sel_o only at T+5; no retrigger at T+5.
- ALU ops: sequence 010, 110, 000, 001, each with ex_valid_i=1; then ALUCtrl_i=011 with ex_valid_i=0 -> stall_o, mul_start_o and result_sel_o stay 0 throughout.
- Back-to-back MULs: two consecutive MULs -> two start pulses 6 cycles apart; result_sel_o at T+5 and T+11; stall_o low only at T+5.
- Flush: flush_i at T+2 during RUN -> IDLE at T+3; stall_o=0 from T+3; result_sel_o never asserted. Separately, flush_i in the detect cycle -> no start pulse. Separately, flush_i in DONE -> result_sel_o=0.
- Parameter edge: MUL_CYCLES=1 -> stall_o for 2 cycles, result_sel_o at T+2. Also rst_i at T+2 of a 4-cycle MUL -> IDLE at T+3 with all outputs 0.

Source files
------------

// File: rtl/mul_issue_control_if.sv
// Handshake bundle between the EX stage and the multiplier issue controller.
// Signal names keep the pipeline's established _i/_o port naming.
interface mul_issue_control_if #(
  parameter int CNT_W = 3
);
  logic             ex_valid_i;
  logic [2:0]       ALUCtrl_i;
  logic             flush_i;
  logic             mul_start_o;
  logic             mul_busy_o;
  logic             stall_o;
  logic             result_sel_o;
  logic [CNT_W-1:0] mul_count_o;

  modport master (
    output ex_valid_i, ALUCtrl_i, flush_i,
    input  mul_start_o, mul_busy_o, stall_o, result_sel_o, mul_count_o
  );

  modport slave (
    input  ex_valid_i, ALUCtrl_i, flush_i,
    output mul_start_o, mul_busy_o, stall_o, result_sel_o, mul_count_o
  );
endinterface

// File: rtl/mul_issue_control.sv
// Issue controller for the iterative multiplier: start pulse, pipeline freeze
// for the multiply duration, and a one-cycle result select into EX/MEM.
//
// state | meaning
// IDLE  | no multiply in flight; a MUL in EX issues a start and stalls
// RUN   | multiplier busy; counter holds remaining RUN cycles
// DONE  | result valid; EX/MEM captures it; MUL still in EX must not retrigger
module mul_issue_control #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mul_issue_control_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_req;

  always_comb mul_req = bus.ex_valid_i && (bus.ALUCtrl_i == 3'b011) && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_req) begin
            state_q <= RUN;
            cnt_q   <= CNT_LOAD;
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Outputs are gated by reset so nothing leaks out combinationally during it.
  assign bus.mul_start_o  = !rst_i && (state_q == IDLE) && mul_req;
  assign bus.stall_o      = !rst_i && (((state_q == IDLE) && mul_req) || (state_q == RUN));
  assign bus.mul_busy_o   = !rst_i && (state_q == RUN);
  assign bus.result_sel_o = !rst_i && (state_q == DONE) && !bus.flush_i;
  assign bus.mul_count_o  = (!rst_i && (state_q == RUN)) ? cnt_q : '0;

endmodule

// File: tb/tb_mul_issue_control.sv
// Self-checking bench for mul_issue_control: directed timing scenarios on a
// 4-cycle and a 1-cycle instance, then randomized traffic against a timeline model.
module tb_mul_issue_control;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mul_issue_control_if #(.CNT_W(3)) bus4 ();
  mul_issue_control_if #(.CNT_W(3)) bus1 ();

  assign bus1.ex_valid_i = bus4.ex_valid_i;
  assign bus1.ALUCtrl_i  = bus4.ALUCtrl_i;
  assign bus1.flush_i    = bus4.flush_i;

  mul_issue_control #(.MUL_CYCLES(4), .CNT_W(3)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus4.slave));
  mul_issue_control #(.MUL_CYCLES(1), .CNT_W(3)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus1.slave));

  // {start, busy, stall, result_sel, count[2:0]}
  logic [6:0] obs4, obs1;
  assign obs4 = {bus4.mul_start_o, bus4.mul_busy_o, bus4.stall_o, bus4.result_sel_o, bus4.mul_count_o};
  assign obs1 = {bus1.mul_start_o, bus1.mul_busy_o, bus1.stall_o, bus1.result_sel_o, bus1.mul_count_o};

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] MUL = 3'b011;

  function automatic logic [6:0] pack(bit s, bit b, bit st, bit rs, int c);
    logic [2:0] c3;
    c3 = 3'(c);
    return {s, b, st, rs, c3};
  endfunction

  // Timeline model: p = cycles since the start pulse, -1 when nothing is in flight.
  // Cycle 0 starts, 1..m are the RUN cycles, m+1 delivers the result.
  function automatic logic [6:0] model_out(int p, int m, bit req, bit fl, bit r);
    if (r) return 7'd0;
    if (p < 0) return pack(req, 1'b0, req, 1'b0, 0);
    if (p <= m) return pack(1'b0, 1'b1, 1'b1, 1'b0, m - p);
    return pack(1'b0, 1'b0, 1'b0, !fl, 0);
  endfunction

  function automatic int model_next(int p, int m, bit req, bit fl, bit r);
    if (r) return -1;
    if (p < 0) return req ? 1 : -1;
    if (p <= m) return fl ? -1 : p + 1;
    return -1;
  endfunction

  // Called just after a falling edge: apply inputs, let combinational outputs settle.
  task automatic drive(bit v, logic [2:0] code, bit fl, bit r);
    bus4.ex_valid_i = v;
    bus4.ALUCtrl_i  = code;
    bus4.flush_i    = fl;
    rst_i           = r;
    #1;
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 3'b000, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, MUL, 1'b0, k < 2);
      exp = (k < 2) ? 7'd0 : pack(1, 0, 1, 0, 0);
      n_checks++;
      if (obs4 !== exp) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    idle_cycles(8);
  endtask

  task automatic test_single_mul();
    logic [6:0] exp;
    for (int k = 0; k <= 6; k++) begin
      drive(k <= 5, MUL, 1'b0, 1'b0);
      exp = pack(k == 0, k >= 1 && k <= 4, k <= 4, k == 5, (k >= 1 && k <= 4) ? 4 - k : 0);
      n_checks++;
      if (obs4 !== exp) begin
        n_fail++;
        $display("FAIL single_mul T+%0d: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    idle_cycles(8);
  endtask

  task automatic test_alu_ops();
    logic [2:0] codes [5];
    codes = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011};
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, codes[k], 1'b0, 1'b0);
      n_checks++;
      if (obs4 !== 7'd0 || obs1 !== 7'd0) begin
        n_fail++;
        $display("FAIL alu_ops code %b: got %b/%b expected 0", codes[k], obs4, obs1);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    int p;
    for (int k = 0; k <= 11; k++) begin
      drive(1'b1, MUL, 1'b0, 1'b0);
      p = k % 6;
      exp = pack(p == 0, p >= 1 && p <= 4, p <= 4, p == 5, (p >= 1 && p <= 4) ? 4 - p : 0);
      n_checks++;
      if (obs4 !== exp) begin
        n_fail++;
        $display("FAIL back_to_back T+%0d: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    idle_cycles(8);
  endtask

  task automatic test_flush();
    logic [6:0] exp;
    for (int k = 0; k <= 6; k++) begin
      drive(k == 0, MUL, k == 2, 1'b0);
      exp = (k == 0) ? pack(1, 0, 1, 0, 0) : (k <= 2) ? pack(0, 1, 1, 0, 4 - k) : 7'd0;
      n_checks++;
      if (obs4 !== exp) begin
        n_fail++;
        $display("FAIL flush_run T+%0d: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drive(k == 0, MUL, k == 0, 1'b0);
      n_checks++;
      if (obs4 !== 7'd0) begin
        n_fail++;
        $display("FAIL flush_detect T+%0d: got %b expected 0", k, obs4);
      end
      step();
    end
    idle_cycles(2);
    for (int k = 0; k <= 6; k++) begin
      drive(k == 0, MUL, k == 5, 1'b0);
      exp = pack(k == 0, k >= 1 && k <= 4, k <= 4, 1'b0, (k >= 1 && k <= 4) ? 4 - k : 0);
      n_checks++;
      if (obs4 !== exp) begin
        n_fail++;
        $display("FAIL flush_done T+%0d: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    idle_cycles(4);
  endtask

  task automatic test_reset_mid_op();
    logic [6:0] exp;
    for (int rk = 2; rk <= 5; rk += 3) begin
      for (int k = 0; k <= 6; k++) begin
        drive(k == 0, MUL, 1'b0, k == rk);
        exp = (k >= rk) ? 7'd0 :
              pack(k == 0, k >= 1 && k <= 4, k <= 4, k == 5, (k >= 1 && k <= 4) ? 4 - k : 0);
        n_checks++;
        if (obs4 !== exp) begin
          n_fail++;
          $display("FAIL reset_at_T+%0d T+%0d: got %b expected %b", rk, k, obs4, exp);
        end
        step();
      end
      idle_cycles(4);
    end
  endtask

  task automatic test_mul_cycles_1();
    logic [6:0] exp;
    for (int k = 0; k <= 3; k++) begin
      drive(k <= 2, MUL, 1'b0, 1'b0);
      exp = pack(k == 0, k == 1, k <= 1, k == 2, 0);
      n_checks++;
      if (obs1 !== exp) begin
        n_fail++;
        $display("FAIL mul_cycles_1 T+%0d: got %b expected %b", k, obs1, exp);
      end
      step();
    end
    idle_cycles(8);
  endtask

  task automatic test_random();
    int p4, p1;
    bit v, fl, r, req;
    logic [2:0] code;
    logic [6:0] e4, e1;
    p4 = -1;
    p1 = -1;
    for (int k = 0; k < 400; k++) begin
      v    = ($urandom % 4) != 0;
      code = ($urandom % 2) ? MUL : 3'($urandom % 8);
      fl   = ($urandom % 10) == 0;
      r    = ($urandom % 40) == 0;
      drive(v, code, fl, r);
      req = v && (code == MUL) && !fl;
      e4 = model_out(p4, 4, req, fl, r);
      e1 = model_out(p1, 1, req, fl, r);
      n_checks++;
      if (obs4 !== e4 || obs1 !== e1) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b/%b expected %b/%b", k, obs4, obs1, e4, e1);
      end
      p4 = model_next(p4, 4, req, fl, r);
      p1 = model_next(p1, 1, req, fl, r);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_alu_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_mul_cycles_1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
